// File: rtl/root_pkg.sv
// Shared state encoding, default widths and helpers for the sequential root/divider family.
package root_pkg;

  localparam int unsigned DEF_IN_W    = 10;
  localparam int unsigned DEF_FRAC_W  = 10;
  localparam int unsigned DEF_EXP_MAX = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MUL,
    ST_CMP,
    ST_DONE
  } root_state_e;

  // A root order is usable when it is non-zero and within the multiplier depth.
  function automatic logic order_legal(input int unsigned n, input int unsigned n_max);
    return (n != 0) && (n <= n_max);
  endfunction

endpackage

// File: rtl/root_pow_unit.sv
// Iterative power datapath: holds trial^k in acc, the shifted radicand as target, and compares them.
module root_pow_unit #(
  parameter int unsigned IN_W   = 10,
  parameter int unsigned FRAC_W = 10,
  parameter int unsigned OUT_W  = 20,
  parameter int unsigned EW     = 3,
  parameter int unsigned PROD_W = 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tgt_load_i,
  input  logic [IN_W-1:0]   x_i,
  input  logic [EW-1:0]     n_i,
  input  logic              acc_load_i,
  input  logic              acc_mul_i,
  input  logic [OUT_W-1:0]  trial_i,
  output logic              lt_c_o,
  output logic              eq_c_o
);

  logic [PROD_W-1:0] acc_q, acc_d;
  logic [PROD_W-1:0] tgt_q, tgt_d;

  // trial^n never exceeds n*OUT_W bits, so truncating the product to PROD_W loses nothing.
  always_comb begin
    acc_d = acc_q;
    if (acc_load_i) begin
      acc_d = PROD_W'(trial_i);
    end else if (acc_mul_i) begin
      acc_d = acc_q * PROD_W'(trial_i);
    end
  end

  // Target scales x by 2^(n*FRAC_W) so integer comparison yields the fixed-point root.
  always_comb begin
    tgt_d = tgt_q;
    if (tgt_load_i) begin
      tgt_d = PROD_W'(x_i) << (32'(n_i) * FRAC_W);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      tgt_q <= '0;
    end else begin
      acc_q <= acc_d;
      tgt_q <= tgt_d;
    end
  end

  assign lt_c_o = (acc_q < tgt_q);
  assign eq_c_o = (acc_q == tgt_q);

endmodule

// File: rtl/nth_root_seq.sv
// Bit-serial fixed-point n-th root: one result bit per LOAD/MUL.../CMP round, MSB first.
module nth_root_seq
  import root_pkg::*;
#(
  parameter  int unsigned IN_W    = DEF_IN_W,
  parameter  int unsigned FRAC_W  = DEF_FRAC_W,
  parameter  int unsigned EXP_MAX = DEF_EXP_MAX,
  localparam int unsigned OUT_W   = IN_W + FRAC_W,
  localparam int unsigned EW      = $clog2(EXP_MAX + 1),
  localparam int unsigned PROD_W  = EXP_MAX * OUT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data_1,
  input  logic [EW-1:0]    in_data_2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_exact,
  output logic             out_err
);

  root_state_e      state_q;
  logic [EW-1:0]    n_q;
  logic [EW-1:0]    cnt_q;
  logic [OUT_W-1:0] result_q;
  logic [OUT_W-1:0] bit_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             out_exact_q;
  logic             out_err_q;

  logic             accept_c;
  logic             legal_c;
  logic             lt_c;
  logic             eq_c;
  logic [OUT_W-1:0] trial_c;

  assign accept_c = in_valid & in_ready_q;
  assign legal_c  = order_legal(32'(in_data_2), EXP_MAX);
  assign trial_c  = result_q | bit_q;

  root_pow_unit #(
    .IN_W   (IN_W),
    .FRAC_W (FRAC_W),
    .OUT_W  (OUT_W),
    .EW     (EW),
    .PROD_W (PROD_W)
  ) u_pow (
    .clk        (clk),
    .rst        (rst),
    .tgt_load_i (accept_c & legal_c),
    .x_i        (in_data_1),
    .n_i        (in_data_2),
    .acc_load_i (state_q == ST_LOAD),
    .acc_mul_i  (state_q == ST_MUL),
    .trial_i    (trial_c),
    .lt_c_o     (lt_c),
    .eq_c_o     (eq_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      n_q         <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      bit_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_exact_q <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_c) begin
            in_ready_q  <= 1'b0;
            result_q    <= '0;
            out_exact_q <= 1'b0;
            out_err_q   <= 1'b0;
            n_q         <= in_data_2;
            bit_q       <= OUT_W'(1) << (OUT_W - 1);
            if (legal_c) begin
              state_q <= ST_LOAD;
            end else begin
              state_q     <= ST_DONE;
              out_err_q   <= 1'b1;
              out_valid_q <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          cnt_q   <= n_q - EW'(1);
          state_q <= (n_q > EW'(1)) ? ST_MUL : ST_CMP;
        end
        ST_MUL: begin
          if (cnt_q == EW'(1)) begin
            state_q <= ST_CMP;
          end else begin
            cnt_q <= cnt_q - EW'(1);
          end
        end
        ST_CMP: begin
          if (lt_c || eq_c) begin
            result_q <= trial_c;
          end
          // An exact hit leaves every lower bit at zero, so stop early.
          if (eq_c || bit_q[0]) begin
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
            out_exact_q <= eq_c;
          end else begin
            bit_q   <= bit_q >> 1;
            state_q <= ST_LOAD;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = result_q;
  assign out_exact = out_exact_q;
  assign out_err   = out_err_q;

endmodule
